// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with status flags. Divide is optional (ALU_DIV_EN) and iterative.
// Latency: 1 cycle for all ops except DIV (OPER_WIDTH+1 edges from accept, inclusive).
// Backpressure: the result slot holds ALU_OUT/flags until OUT_READY; IN_READY drops while full or dividing.
//
// Ports:
//   ALU_CLK, RST (async, active low)
//   A, B, ALU_FUN, IN_VALID / IN_READY          operand/opcode input handshake
//   ALU_OUT, ZERO, CARRY, ERR, OUT_VALID / OUT_READY   registered result slot
// Build option: define ALU_DIV_EN to build the restoring divider and its DIV state;
// without it opcode 0011 returns 0 with ERR=1 in one cycle.
module alu_pipe #(
  parameter int OPER_WIDTH = 8
) (
  input  logic                      ALU_CLK,
  input  logic                      RST,
  input  logic [OPER_WIDTH-1:0]     A,
  input  logic [OPER_WIDTH-1:0]     B,
  input  logic [3:0]                ALU_FUN,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  output logic [2*OPER_WIDTH-1:0]   ALU_OUT,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic                      ZERO,
  output logic                      CARRY,
  output logic                      ERR
);

  localparam int W         = OPER_WIDTH;
  localparam int OUT_WIDTH = 2 * OPER_WIDTH;

  logic                 accept;
  logic                 pop;
  logic                 load_single;
  logic [OUT_WIDTH-1:0] res_d;
  logic                 carry_d;
  logic                 err_d;
  logic [W:0]           sum_w;
  logic [W-1:0]         diff_w;
  logic [OUT_WIDTH-1:0] prod_w;
  logic [W-1:0]         lo_w;

  assign accept = IN_VALID && IN_READY;
  assign pop    = OUT_VALID && OUT_READY;

  assign sum_w  = {1'b0, A} + {1'b0, B};
  assign diff_w = A - B;
  assign prod_w = {{W{1'b0}}, A} * {{W{1'b0}}, B};

  // W-bit bitwise results share one zero-extension path
  always_comb begin
    lo_w = '0;
    case (ALU_FUN)
      4'b0100: lo_w = A & B;
      4'b0101: lo_w = A | B;
      4'b0110: lo_w = ~(A & B);
      4'b0111: lo_w = ~(A | B);
      4'b1000: lo_w = A ^ B;
      4'b1001: lo_w = ~(A ^ B);
      default: lo_w = '0;
    endcase
  end

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    err_d   = 1'b0;
    case (ALU_FUN)
      4'b0000: begin
        res_d   = {{(W-1){1'b0}}, sum_w};
        carry_d = sum_w[W];
      end
      4'b0001: begin
        res_d   = {{W{1'b0}}, diff_w};
        carry_d = (A < B);
      end
      4'b0010: res_d = prod_w;
      // Only reaches the result slot when there is no divider or B==0
      4'b0011: err_d = 1'b1;
      4'b0100, 4'b0101, 4'b0110,
      4'b0111, 4'b1000, 4'b1001: res_d = {{W{1'b0}}, lo_w};
      4'b1010: res_d = (A == B) ? {{(OUT_WIDTH-2){1'b0}}, 2'd1} : '0;
      4'b1011: res_d = (A > B)  ? {{(OUT_WIDTH-2){1'b0}}, 2'd2} : '0;
      4'b1100: res_d = (A < B)  ? {{(OUT_WIDTH-2){1'b0}}, 2'd3} : '0;
      4'b1101: res_d = {{W{1'b0}}, 1'b0, A[W-1:1]};
      4'b1110: res_d = {{(W-1){1'b0}}, A, 1'b0};
      default: err_d = 1'b1;
    endcase
  end

`ifdef ALU_DIV_EN
  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic {IDLE, DIV} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   a_q;     // dividend shifting out, quotient shifting in
  logic [W-1:0]   b_q;
  logic [W-1:0]   rem_q;
  logic           start_div;
  logic           div_done;
  logic [W:0]     shifted;
  logic           ge;
  logic [W-1:0]   rem_nx;
  logic [W-1:0]   quo_nx;

  assign start_div   = accept && (ALU_FUN == 4'b0011) && (B != '0);
  assign load_single = accept && !start_div;
  assign IN_READY    = (state_q == IDLE) && (!OUT_VALID || OUT_READY);

  // One restoring step: since rem < b, shifted - b always fits in W bits
  assign shifted  = {rem_q, a_q[W-1]};
  assign ge       = (shifted >= {1'b0, b_q});
  assign rem_nx   = ge ? (shifted[W-1:0] - b_q) : shifted[W-1:0];
  assign quo_nx   = {a_q[W-2:0], ge};
  assign div_done = (state_q == DIV) && (cnt_q == CW'(W-1));

  always_ff @(posedge ALU_CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_div) begin
            state_q <= DIV;
            a_q     <= A;
            b_q     <= B;
            rem_q   <= '0;
            cnt_q   <= '0;
          end
        end
        DIV: begin
          a_q   <= quo_nx;
          rem_q <= rem_nx;
          if (div_done) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  assign load_single = accept;
  assign IN_READY    = !OUT_VALID || OUT_READY;
`endif

  // Result slot: a load wins over a pop so pop+accept keeps OUT_VALID high
  always_ff @(posedge ALU_CLK or negedge RST) begin
    if (!RST) begin
      ALU_OUT   <= '0;
      OUT_VALID <= 1'b0;
      ZERO      <= 1'b0;
      CARRY     <= 1'b0;
      ERR       <= 1'b0;
    end else if (load_single) begin
      ALU_OUT   <= res_d;
      ZERO      <= (res_d == '0);
      CARRY     <= carry_d;
      ERR       <= err_d;
      OUT_VALID <= 1'b1;
`ifdef ALU_DIV_EN
    end else if (div_done) begin
      ALU_OUT   <= {rem_nx, quo_nx};
      ZERO      <= ({rem_nx, quo_nx} == '0);
      CARRY     <= 1'b0;
      ERR       <= 1'b0;
      OUT_VALID <= 1'b1;
`endif
    end else if (pop) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table for single-cycle ops plus hand sequences
// for divide latency, back-pressure hold, pop+accept replacement and reset mid-divide.
// Expected values are hand-computed for OPER_WIDTH = 8.
module tb_alu_pipe;

  localparam int W = 8;

  logic            ALU_CLK = 1'b0;
  logic            RST;
  logic [W-1:0]    A;
  logic [W-1:0]    B;
  logic [3:0]      ALU_FUN;
  logic            IN_VALID;
  logic            IN_READY;
  logic [2*W-1:0]  ALU_OUT;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic            ZERO;
  logic            CARRY;
  logic            ERR;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [3:0]     fun;
    logic [2*W-1:0] out;
    logic           z;
    logic           c;
    logic           e;
  } vec_t;

  vec_t vecs[$];

  alu_pipe #(.OPER_WIDTH(W)) dut (
    .ALU_CLK   (ALU_CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .ALU_FUN   (ALU_FUN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .ALU_OUT   (ALU_OUT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .ZERO      (ZERO),
    .CARRY     (CARRY),
    .ERR       (ERR)
  );

  always #5 ALU_CLK = ~ALU_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] fun,
                         input logic [2*W-1:0] out, input logic z, input logic c, input logic e);
    vec_t v;
    v.a = a; v.b = b; v.fun = fun; v.out = out; v.z = z; v.c = c; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge ALU_CLK);
    @(negedge ALU_CLK);
  endtask

`ifdef ALU_DIV_EN
  // Drive one DIV, count edges until OUT_VALID (E0 counts as edge 1)
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp);
    int edges;
    logic busy_ok;
    A = a; B = b; ALU_FUN = 4'b0011; IN_VALID = 1'b1; OUT_READY = 1'b1;
    step();
    IN_VALID = 1'b0;
    edges = 1;
    busy_ok = 1'b1;
    while (!OUT_VALID && edges < 20) begin
      if (IN_READY) busy_ok = 1'b0;
      step();
      edges++;
    end
    check("div_latency", edges, 9);
    check("div_in_ready_low", busy_ok, 1'b1);
    check("div_out", ALU_OUT, exp);
    check("div_zero", ZERO, (exp == '0));
    check("div_err", ERR, 1'b0);
    check("div_carry", CARRY, 1'b0);
    check("div_in_ready_after", IN_READY, 1'b1);
    step();
  endtask
`endif

  initial begin
    logic stale;

    RST = 1'b0; A = '0; B = '0; ALU_FUN = '0; IN_VALID = 1'b0; OUT_READY = 1'b1;

    //       a       b       fun      out        z     c     e
    add_vec(8'd200, 8'd100, 4'b0000, 16'h012C, 1'b0, 1'b1, 1'b0);
    add_vec(8'd5,   8'd7,   4'b0001, 16'h00FE, 1'b0, 1'b1, 1'b0);
    add_vec(8'd9,   8'd9,   4'b1010, 16'h0001, 1'b0, 1'b0, 1'b0);
    add_vec(8'd0,   8'd0,   4'b0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    add_vec(8'd255, 8'd1,   4'b0000, 16'h0100, 1'b0, 1'b1, 1'b0);
    add_vec(8'd7,   8'd5,   4'b0001, 16'h0002, 1'b0, 1'b0, 1'b0);
    add_vec(8'd5,   8'd5,   4'b0001, 16'h0000, 1'b1, 1'b0, 1'b0);
    add_vec(8'd255, 8'd255, 4'b0010, 16'hFE01, 1'b0, 1'b0, 1'b0);
    add_vec(8'd12,  8'd0,   4'b0010, 16'h0000, 1'b1, 1'b0, 1'b0);
    add_vec(8'hF0,  8'h3C,  4'b0100, 16'h0030, 1'b0, 1'b0, 1'b0);
    add_vec(8'hF0,  8'h3C,  4'b0101, 16'h00FC, 1'b0, 1'b0, 1'b0);
    add_vec(8'hF0,  8'h3C,  4'b0110, 16'h00CF, 1'b0, 1'b0, 1'b0);
    add_vec(8'hF0,  8'h3C,  4'b0111, 16'h0003, 1'b0, 1'b0, 1'b0);
    add_vec(8'hF0,  8'h3C,  4'b1000, 16'h00CC, 1'b0, 1'b0, 1'b0);
    add_vec(8'hF0,  8'h3C,  4'b1001, 16'h0033, 1'b0, 1'b0, 1'b0);
    add_vec(8'd9,   8'd8,   4'b1010, 16'h0000, 1'b1, 1'b0, 1'b0);
    add_vec(8'd10,  8'd3,   4'b1011, 16'h0002, 1'b0, 1'b0, 1'b0);
    add_vec(8'd3,   8'd10,  4'b1011, 16'h0000, 1'b1, 1'b0, 1'b0);
    add_vec(8'd3,   8'd10,  4'b1100, 16'h0003, 1'b0, 1'b0, 1'b0);
    add_vec(8'd3,   8'd3,   4'b1100, 16'h0000, 1'b1, 1'b0, 1'b0);
    add_vec(8'h81,  8'd0,   4'b1101, 16'h0040, 1'b0, 1'b0, 1'b0);
    add_vec(8'h81,  8'd0,   4'b1110, 16'h0102, 1'b0, 1'b0, 1'b0);
    add_vec(8'h00,  8'd0,   4'b1110, 16'h0000, 1'b1, 1'b0, 1'b0);
    add_vec(8'd55,  8'd66,  4'b1111, 16'h0000, 1'b1, 1'b0, 1'b1);
    add_vec(8'd100, 8'd0,   4'b0011, 16'h0000, 1'b1, 1'b0, 1'b1);
    add_vec(8'd1,   8'd1,   4'b0000, 16'h0002, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(negedge ALU_CLK);
    check("rst_out", ALU_OUT, 16'h0000);
    check("rst_valid", OUT_VALID, 1'b0);
    check("rst_zero", ZERO, 1'b0);
    check("rst_carry", CARRY, 1'b0);
    check("rst_err", ERR, 1'b0);
    RST = 1'b1;
    #1;
    check("ready_after_reset", IN_READY, 1'b1);
    @(negedge ALU_CLK);

    // Back-to-back single-cycle ops, one per clock
    for (int i = 0; i < vecs.size(); i++) begin
      A = vecs[i].a; B = vecs[i].b; ALU_FUN = vecs[i].fun; IN_VALID = 1'b1;
      #1;
      check($sformatf("vec%0d_in_ready", i), IN_READY, 1'b1);
      step();
      check($sformatf("vec%0d_valid", i), OUT_VALID, 1'b1);
      check($sformatf("vec%0d_out", i), ALU_OUT, vecs[i].out);
      check($sformatf("vec%0d_zero", i), ZERO, vecs[i].z);
      check($sformatf("vec%0d_carry", i), CARRY, vecs[i].c);
      check($sformatf("vec%0d_err", i), ERR, vecs[i].e);
    end
    IN_VALID = 1'b0;
    step();
    check("pop_clears_valid", OUT_VALID, 1'b0);

`ifdef ALU_DIV_EN
    do_div(8'd100, 8'd7,   16'h020E);
    do_div(8'd255, 8'd16,  16'h0F0F);
    do_div(8'd7,   8'd100, 16'h0700);
    do_div(8'd0,   8'd3,   16'h0000);
`else
    A = 8'd100; B = 8'd7; ALU_FUN = 4'b0011; IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    check("nodiv_valid", OUT_VALID, 1'b1);
    check("nodiv_out", ALU_OUT, 16'h0000);
    check("nodiv_err", ERR, 1'b1);
    check("nodiv_zero", ZERO, 1'b1);
    step();
`endif

    // Back-pressure: MUL result held for 5 cycles, then pop + accept replaces it
    A = 8'd255; B = 8'd255; ALU_FUN = 4'b0010; IN_VALID = 1'b1; OUT_READY = 1'b0;
    step();
    A = 8'd1; B = 8'd2; ALU_FUN = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d_valid", k), OUT_VALID, 1'b1);
      check($sformatf("hold%0d_out", k), ALU_OUT, 16'hFE01);
      check($sformatf("hold%0d_in_ready", k), IN_READY, 1'b0);
      step();
    end
    OUT_READY = 1'b1;
    #1;
    check("pop_in_ready", IN_READY, 1'b1);
    step();
    check("replace_valid", OUT_VALID, 1'b1);
    check("replace_out", ALU_OUT, 16'h0003);
    IN_VALID = 1'b0;
    step();
    check("replace_popped", OUT_VALID, 1'b0);

`ifdef ALU_DIV_EN
    // Reset during the 4th DIV cycle abandons the division
    A = 8'd100; B = 8'd7; ALU_FUN = 4'b0011; IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    repeat (3) step();
    check("middiv_out_before", ALU_OUT, 16'h0003);
    check("middiv_busy", IN_READY, 1'b0);
    RST = 1'b0;
    #1;
    check("middiv_rst_out", ALU_OUT, 16'h0000);
    check("middiv_rst_valid", OUT_VALID, 1'b0);
    check("middiv_rst_ready", IN_READY, 1'b1);
`else
    // Reset while an error result is held under back-pressure
    A = 8'd100; B = 8'd7; ALU_FUN = 4'b0011; IN_VALID = 1'b1; OUT_READY = 1'b0;
    step();
    IN_VALID = 1'b0;
    check("held_err", ERR, 1'b1);
    RST = 1'b0;
    #1;
    check("heldrst_valid", OUT_VALID, 1'b0);
    check("heldrst_err", ERR, 1'b0);
    check("heldrst_zero", ZERO, 1'b0);
    OUT_READY = 1'b1;
`endif
    @(negedge ALU_CLK);
    RST = 1'b1;
    #1;
    check("post_rst_ready", IN_READY, 1'b1);
    stale = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (OUT_VALID) stale = 1'b1;
    end
    check("no_stale_result", stale, 1'b0);
    check("no_stale_out", ALU_OUT, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the single-cycle ALU in the register-file/ALU datapath. Accepts operand pairs over a valid/ready interface and returns results with status flags. Single-cycle operations have one-cycle latency; division runs on an iterative restoring divider that takes OPER_WIDTH cycles. The output is held under back-pressure, so the system controller can stall the ALU safely.

## Interface
- OPER_WIDTH, 8: operand width in bits, ≥2.
- OUT_WIDTH, 2*OPER_WIDTH: result width; fixed derivation, not overridable.
- ALU_CLK  in  1  single clock, all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- A, B  in  OPER_WIDTH  unsigned operands.
- ALU_FUN  in  4  opcode.
- IN_VALID  in  1  operands/opcode valid.
- IN_READY  out  1  block can accept; IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY).
- ALU_OUT  out  OUT_WIDTH  registered result.
- OUT_VALID  out  1  ALU_OUT/flags valid.
- OUT_READY  in  1  consumer takes result.
- ZERO, CARRY, ERR  out  1 each  registered flags, updated together with ALU_OUT.

## Operation
- Accept: IN_VALID && IN_READY at a rising edge latches A, B and ALU_FUN.
- Opcode map (results zero-extended to OUT_WIDTH):
  - 0000 ADD: W+1-bit sum; CARRY = bit W.
  - 0001 SUB: low W bits = A−B mod 2^W; CARRY = borrow (A<B).
  - 0010 MUL: full 2W-bit product.
  - 0011 DIV: {remainder, quotient}, each W bits.
  - 0100 AND, 0101 OR, 0110 NAND, 0111 NOR, 1000 XOR, 1001 XNOR: W-bit results.
  - 1010 EQ: result 1 if A==B, else 0.
  - 1011 GT: result 2 if A>B, else 0.
  - 1100 LT: result 3 if A<B, else 0.
  - 1101 SHR: A>>1.
  - 1110 SHL: A<<1, W+1 bits, so bit W is kept.
  - 1111: result 0, ERR=1.
- ZERO = (ALU_OUT==0) for every op. CARRY = 0 for ops other than ADD and SUB. ERR = 0 unless stated otherwise.
- FSM:
  - IDLE: on accept of a non-DIV op, register the result and set OUT_VALID; stay in IDLE.
  - IDLE → DIV: on accept of DIV with B≠0; load the remainder register with 0 and the iteration counter with 0.
  - DIV: one restoring step per cycle, counter increments. When the counter reaches OPER_WIDTH−1, register {rem, quot}, set OUT_VALID and return to IDLE.
  - DIV with B==0: no DIV state. ALU_OUT=0, ERR=1, ZERO=1, latency as a single-cycle op.
- Output slot: OUT_VALID stays high and ALU_OUT/flags stay stable until OUT_VALID && OUT_READY. If no new result loads on that edge, OUT_VALID clears.
- Simultaneous pop and accept (single-cycle op): the new result replaces the old one on the same edge and OUT_VALID stays 1.
- IN_READY is 0 throughout DIV and while an unconsumed result is held with OUT_READY=0.

## Timing
- Reset (asynchronous, RST=0): ALU_OUT=0, OUT_VALID=0, ZERO=0, CARRY=0, ERR=0, state=IDLE, counter=0, operand registers=0.
- IN_READY=1 in the first cycle after reset release.
- Single-cycle op accepted at edge E0: OUT_VALID=1 after E0 (latency 1).
- DIV accepted at E0: iterations occur at edges E1..E_W; OUT_VALID=1 after edge E_W (latency OPER_WIDTH+1 edges from accept, inclusive). IN_READY returns after E_W only if OUT_READY=1.
- Reset asserted mid-division: divider state is abandoned and no result is produced.
- Throughput: one single-cycle op per clock when OUT_READY=1 continuously.

## Configuration
- ALU_DIV_EN defined: iterative divider and DIV state are built as described above.
- ALU_DIV_EN undefined: no divider hardware and no DIV state. Opcode 0011 returns ALU_OUT=0, ERR=1, ZERO=1 with latency 1. All other opcodes are unchanged.

## Test plan
- Reset release, then A=200, B=100, ADD, OUT_READY=1 → next cycle ALU_OUT=0x012C, CARRY=1, ZERO=0, OUT_VALID=1.
- A=5, B=7, SUB → ALU_OUT=0x00FE, CARRY=1; then A=9, B=9, EQ back-to-back → ALU_OUT=1 one cycle later, no bubble.
- A=100, B=7, DIV (ALU_DIV_EN defined) → IN_READY=0 for 8 cycles, then ALU_OUT=0x020E, OUT_VALID=1 exactly 9 edges after accept. Also A=100, B=0, DIV → ALU_OUT=0, ERR=1, latency 1.
- MUL 255×255 with OUT_READY=0 for 5 cycles → ALU_OUT=0xFE01 held stable, IN_READY=0. On the OUT_READY=1 cycle, a simultaneous new accept replaces the result.
- Assert RST at the 4th DIV cycle → all outputs 0 immediately. After release, IN_READY=1 and no stale result appears.
- Build without ALU_DIV_EN, A=100, B=7, DIV → ALU_OUT=0, ERR=1, ZERO=1 after one cycle.
